// File: rtl/alu_pkg.sv
// Purpose: shared opcode and FSM state encodings for the sequential ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // ALUop encodings presented on the 3-bit opcode input
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOTB = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_LSL  = 3'b110,
        OP_MUL  = 3'b111
    } alu_op_e;

    // Control FSM: IDLE accepts work, MUL is the iterative multiply
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Purpose: operand/opcode request side and result/flag side of the ALU.
// Latency: n/a (wiring only).
// Backpressure: in_ready qualifies in_valid; results are unthrottled pulses.
// Ports: in_valid/in_ready/ALUop/Ain/Bin (request), out/out_valid/Z/N/V (result).
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             Z;
    logic             N;
    logic             V;

    // master issues operations and consumes results
    modport master (
        output in_valid, ALUop, Ain, Bin,
        input  in_ready, out, out_valid, Z, N, V
    );

    // slave is the ALU itself
    modport slave (
        input  in_valid, ALUop, Ain, Bin,
        output in_ready, out, out_valid, Z, N, V
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Purpose: shift-add multiplier, one partial product per step, low WIDTH bits kept.
// Latency: WIDTH steps after i_load; o_done flags the final step.
// Backpressure: none; the caller owns pacing via i_step.
// Ports: clk, reset, i_load, i_step, i_a, i_b in; o_acc, o_done out.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_done
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // o_acc already includes the step taken on this edge, so on the final
    // step the caller can register the product in the same edge as cnt->0.
    assign o_acc  = w_acc_nxt;
    assign o_done = i_step && (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
        end else if (i_step && (r_cnt != '0)) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Purpose: registered 8-op ALU with Z/N/V flags and an iterative multiply.
// Latency: 1 cycle for ADD..LSL, WIDTH+1 cycles for MUL (fixed).
// Backpressure: in_ready low while a multiply is in flight; in_valid then ignored.
// Ports: clk, reset (sync, active-high), bus (alu_seq_if.slave).
// WIDTH must be >= 4 and a power of two so the shift amount field is exact.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    alu_state_e       r_state;
    alu_state_e       w_state_nxt;

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_z;
    logic             r_n;
    logic             r_v;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_load;
    logic             w_mul_step;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_acc;
    logic             w_single_load;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_v;

    // Ready drops combinationally with reset so an op presented alongside
    // reset is never considered accepted.
    assign w_in_ready    = (r_state == ST_IDLE) && !reset;
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_is_mul      = (bus.ALUop == OP_MUL);
    assign w_single_load = w_accept && !w_is_mul;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_mul_load),
        .i_step (w_mul_step),
        .i_a    (bus.Ain),
        .i_b    (bus.Bin),
        .o_acc  (w_mul_acc),
        .o_done (w_mul_done)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and multiplier controls
    always_comb begin
        w_state_nxt = r_state;
        w_mul_load  = 1'b0;
        w_mul_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_mul_load  = 1'b1;
                    w_state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                w_mul_step = 1'b1;
                if (w_mul_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Single-cycle result mux and signed overflow
    always_comb begin
        w_sum  = bus.Ain + bus.Bin;
        w_diff = bus.Ain - bus.Bin;
        w_res  = '0;
        w_v    = 1'b0;
        case (bus.ALUop)
            OP_ADD: begin
                w_res = w_sum;
                // like-signed operands producing an opposite-signed sum
                w_v   = (bus.Ain[MSB] == bus.Bin[MSB]) && (w_sum[MSB] != bus.Ain[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff;
                // unlike-signed operands where the result loses A's sign
                w_v   = (bus.Ain[MSB] != bus.Bin[MSB]) && (w_diff[MSB] != bus.Ain[MSB]);
            end
            OP_AND:  w_res = bus.Ain & bus.Bin;
            OP_NOTB: w_res = ~bus.Bin;
            OP_OR:   w_res = bus.Ain | bus.Bin;
            OP_XOR:  w_res = bus.Ain ^ bus.Bin;
            OP_LSL:  w_res = bus.Ain << bus.Bin[SHW-1:0];
            default: w_res = '0;  // MUL result comes from the multiplier
        endcase
    end

    // Result and flag registers; out_valid is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_single_load) begin
                r_out       <= w_res;
                r_z         <= (w_res == '0);
                r_n         <= w_res[MSB];
                r_v         <= w_v;
                r_out_valid <= 1'b1;
            end else if (w_mul_done) begin
                r_out       <= w_mul_acc;
                r_z         <= (w_mul_acc == '0);
                r_n         <= w_mul_acc[MSB];
                r_v         <= 1'b0;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.Z         = r_z;
    assign bus.N         = r_n;
    assign bus.V         = r_v;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU (ADD/SUB/AND/NOT B with Z).
- Widens the opcode to 8 operations, adds N and V status flags, an iterative multiply and a valid/ready input handshake.
- Sits between the register-file A/B operand latches and the C write-back register; its flag outputs feed the status register used by conditional branches.

Parameters:
- WIDTH, 16, datapath width in bits; must be 4 or more and a power of two.
- SHW, $clog2(WIDTH), localparam (not overridable); width of the shift amount taken from B.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode are presented this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- ALUop  in  3  opcode; values defined in alu_pkg.
- Ain  in  WIDTH  operand A.
- Bin  in  WIDTH  operand B.
- out  out  WIDTH  registered result.
- out_valid  out  1  one-cycle pulse; out and the flags are new this cycle.
- Z  out  1  zero flag: out == 0.
- N  out  1  negative flag: out[WIDTH-1].
- V  out  1  signed overflow flag.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: out=0, Z=0, N=0, V=0, out_valid=0, state=IDLE, in_ready=1 in the cycle after reset deasserts.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND: A&B.
  - 011 NOTB: ~B.
  - 100 OR: A|B.
  - 101 XOR: A^B.
  - 110 LSL: A << B[SHW-1:0].
  - 111 MUL: low WIDTH bits of A*B, unsigned.
- Arithmetic: all arithmetic is modulo 2^WIDTH. V is the signed two's-complement overflow for ADD and SUB and is 0 for every other opcode.
- Handshake: an operation is accepted on an edge where in_valid && in_ready. in_ready = (state==IDLE) && !reset. in_valid while in_ready=0 is ignored; nothing is captured or queued.
- States:
  - IDLE: single-cycle ops are accepted here.
  - MUL: iterative multiply in progress.
- Single-cycle ops (000-110), accepted at edge E:
  - out, Z, N and V are registered at E.
  - out_valid=1 for exactly the one cycle after E (latency 1).
  - State stays IDLE, so back-to-back acceptance gives an out_valid on every cycle.
- MUL, accepted at edge E:
  - Operands are latched, the accumulator is cleared, cnt=WIDTH, state=MUL, in_ready=0.
  - On each of the next WIDTH edges: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt -= 1.
  - At the edge where cnt reaches 0 (edge E+WIDTH): out=acc, flags updated, V=0, state=IDLE.
  - out_valid=1 for the one cycle after edge E+WIDTH; total latency is WIDTH+1.
  - in_ready returns to 1 in that same cycle, so a new op may be accepted in the out_valid cycle.
- Holding: out and the flags hold their values between results. out_valid is never asserted except as described above.
- Reset mid-MUL: the operation is aborted; no out_valid is emitted; all outputs return to their reset values.
- reset together with in_valid: reset wins and the operation is not accepted.
- Edge cases:
  - LSL with a shift amount of 0 returns A unchanged.
  - MUL with a zero operand still takes the full WIDTH+1 cycles (fixed latency).

Decomposition:
- alu_pkg holds:
  - ALUop constants: OP_ADD, OP_SUB, OP_AND, OP_NOTB, OP_OR, OP_XOR, OP_LSL, OP_MUL.
  - State encodings: ST_IDLE, ST_MUL.
- One sub-module, alu_mul_iter: the shift-add multiplier, with load/step inputs and acc/done outputs, parametrised by WIDTH.
- The combinational op mux and the flag logic stay in alu_seq.

Test Plan (WIDTH=16):
- ADD A=0x7FFF, B=0x0001 -> next cycle out=0x8000, N=1, V=1, Z=0, out_valid pulses for one cycle.
- SUB A=5, B=5, then back-to-back NOTB B=0x5555 -> out=0 with Z=1, then out=0xAAAA with N=1; out_valid high on two consecutive cycles.
- AND A=2, B=2 -> out=0x0002. Then LSL A=0x0003, B=0x0004 -> out=0x0030. Then OR/XOR with A=0x00F0, B=0x0FF0 -> 0x0FF0 / 0x0F00.
- MUL A=300, B=300 -> in_ready=0 for 16 cycles; out=0x5F90 with out_valid exactly 17 cycles after acceptance; V=0. An in_valid ADD presented during the busy window produces no result.
- MUL in progress with reset asserted at the 5th busy cycle -> no out_valid; out=0, flags=0, in_ready=1 in the cycle after reset deasserts. A following ADD 2+1 gives out=3.
- ADD 0xFFFF+1 -> out=0, Z=1, V=0. Then SUB 0x8000-1 -> out=0x7FFF, V=1, N=0.
